// File: rtl/mem_arb_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter: FSM states, owner ids, latched request.
// Imported by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam logic OWNER_IFU = 1'b0;
   localparam logic OWNER_LSU = 1'b1;

   localparam int LAT_W = 4;

   typedef struct packed {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wmask;
      logic        owner;
   } req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way grant, zero latency; a grant is only ever given to a valid requester.
// Fixed LSU-over-IFU priority, or round-robin against i_last_grant when MEM_ARB_RR_EN is defined.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic i_ifu_vld,
   input  logic i_lsu_vld,
`ifdef MEM_ARB_RR_EN
   input  logic i_last_grant,
`endif
   output logic o_gnt_ifu,
   output logic o_gnt_lsu
);

   logic w_lsu_wins;

`ifdef MEM_ARB_RR_EN
   assign w_lsu_wins = (i_last_grant == OWNER_IFU);
`else
   assign w_lsu_wins = 1'b1;
`endif

   assign o_gnt_lsu = i_lsu_vld & (~i_ifu_vld | w_lsu_wins);
   assign o_gnt_ifu = i_ifu_vld & (~i_lsu_vld | ~w_lsu_wins);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU: accept -> access after LATENCY cycles -> held response.
// One request in flight; requesters stall on ready until the response handshakes. MEM_ARB_RR_EN selects round-robin.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int LATENCY = 1
)
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ifu_req_valid,
   output logic        o_ifu_req_ready,
   input  logic [63:0] i_ifu_req_addr,
   output logic        o_ifu_rsp_valid,
   input  logic        i_ifu_rsp_ready,
   output logic [63:0] o_ifu_rsp_data,
   input  logic        i_lsu_req_valid,
   output logic        o_lsu_req_ready,
   input  logic [63:0] i_lsu_req_addr,
   input  logic        i_lsu_req_wen,
   input  logic [63:0] i_lsu_req_wdata,
   input  logic [7:0]  i_lsu_req_wmask,
   output logic        o_lsu_rsp_valid,
   input  logic        i_lsu_rsp_ready,
   output logic [63:0] o_lsu_rsp_data,
   output logic [63:0] o_mem_raddr,
   output logic [63:0] o_mem_waddr,
   output logic [63:0] o_mem_wdata,
   output logic [7:0]  o_mem_wmask,
   output logic        o_mem_read_en,
   output logic        o_mem_write_en,
   input  logic [63:0] i_mem_rdata
);

   localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);

   state_t           r_state;
   req_t             r_req;
   logic [LAT_W-1:0] r_cnt;
   logic [63:0]      r_rsp_data;
   logic             r_ifu_rsp_valid;
   logic             r_lsu_rsp_valid;
`ifdef MEM_ARB_RR_EN
   logic             r_last_grant;
`endif

   logic w_gnt_ifu;
   logic w_gnt_lsu;
   logic w_idle;
   logic w_access;
   logic w_accept;
   logic w_rsp_done;
   req_t w_new_req;

   mem_arb_pick u_pick (
      .i_ifu_vld    (i_ifu_req_valid),
      .i_lsu_vld    (i_lsu_req_valid),
`ifdef MEM_ARB_RR_EN
      .i_last_grant (r_last_grant),
`endif
      .o_gnt_ifu    (w_gnt_ifu),
      .o_gnt_lsu    (w_gnt_lsu)
   );

   assign w_idle   = (r_state == IDLE) & ~i_rst;
   assign w_access = (r_state == ACCESS) & ~i_rst;

   assign o_ifu_req_ready = w_idle & w_gnt_ifu;
   assign o_lsu_req_ready = w_idle & w_gnt_lsu;
   assign w_accept        = o_ifu_req_ready | o_lsu_req_ready;

   // IFU requests carry no write payload, so its latched data/mask are zero.
   always_comb begin
      w_new_req = '0;
      if (w_gnt_lsu) begin
         w_new_req.owner = OWNER_LSU;
         w_new_req.addr  = i_lsu_req_addr;
         w_new_req.wen   = i_lsu_req_wen;
         w_new_req.wdata = i_lsu_req_wdata;
         w_new_req.wmask = i_lsu_req_wmask;
      end else begin
         w_new_req.owner = OWNER_IFU;
         w_new_req.addr  = i_ifu_req_addr;
      end
   end

   assign w_rsp_done = (r_ifu_rsp_valid & i_ifu_rsp_ready) | (r_lsu_rsp_valid & i_lsu_rsp_ready);

   assign o_mem_read_en  = w_access & ~r_req.wen;
   assign o_mem_write_en = w_access &  r_req.wen;
   assign o_mem_raddr    = r_req.addr;
   assign o_mem_waddr    = r_req.addr;
   assign o_mem_wdata    = r_req.wdata;
   assign o_mem_wmask    = r_req.wmask;

   assign o_ifu_rsp_valid = r_ifu_rsp_valid;
   assign o_lsu_rsp_valid = r_lsu_rsp_valid;
   assign o_ifu_rsp_data  = r_rsp_data;
   assign o_lsu_rsp_data  = r_rsp_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state         <= IDLE;
         r_req           <= '0;
         r_cnt           <= '0;
         r_rsp_data      <= '0;
         r_ifu_rsp_valid <= 1'b0;
         r_lsu_rsp_valid <= 1'b0;
`ifdef MEM_ARB_RR_EN
         r_last_grant    <= OWNER_IFU;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_req   <= w_new_req;
                  r_cnt   <= LAT_M1;
                  r_state <= (LATENCY > 1) ? WAIT : ACCESS;
`ifdef MEM_ARB_RR_EN
                  r_last_grant <= w_new_req.owner;
`endif
               end
            end
            WAIT: begin
               // Leaving on 1 means the counter reads 0 in the ACCESS cycle.
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == LAT_W'(1)) begin
                  r_state <= ACCESS;
               end
            end
            ACCESS: begin
               r_rsp_data      <= r_req.wen ? 64'd0 : i_mem_rdata;
               r_ifu_rsp_valid <= (r_req.owner == OWNER_IFU);
               r_lsu_rsp_valid <= (r_req.owner == OWNER_LSU);
               r_state         <= RESP;
            end
            RESP: begin
               if (w_rsp_done) begin
                  r_ifu_rsp_valid <= 1'b0;
                  r_lsu_rsp_valid <= 1'b0;
                  r_state         <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter at LATENCY 1 and 3: queue scoreboard fed by a cycle-count model.
// Model grants on free cycles, predicts access cycle = accept+LATENCY and response from accept+LATENCY+1.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          due;
      logic        wen;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } acc_t;

   typedef struct {
      int          first;
      logic        owner;
      logic [63:0] data;
   } rsp_t;

   task automatic chk(input int lat, input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL L%0d %s actual=%h expected=%h", lat, name, act, exp);
      end
   endtask

   function automatic logic [63:0] mem_fn(input logic [63:0] a);
      if (a == 64'h8000_0000) return 64'h1234;
      return {a[31:0] ^ 32'hC0FF_EE11, a[63:32] ^ 32'h5EED_0001};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gen_lat
      localparam int LAT = (g == 0) ? 1 : 3;

      logic        rst, iv, lv, lwen, irr, lrr;
      logic [63:0] iaddr, laddr, lwdata;
      logic [7:0]  lwmask;
      logic        ifu_rdy, lsu_rdy, ifu_rv, lsu_rv, rd_en, wr_en;
      logic [63:0] ifu_rd, lsu_rd, raddr, waddr, wdata_o, rdata;
      logic [7:0]  wmask_o;

      acc_t acc_q[$];
      rsp_t rsp_q[$];
      int   cyc = 0;
      int   n_acc_i = 0;
      int   n_acc_l = 0;
      logic last = OWNER_IFU;
      logic done_b = 1'b0;

      assign rdata = mem_fn(raddr);

      mem_arbiter #(.LATENCY(LAT)) u_dut (
         .i_clk           (clk),
         .i_rst           (rst),
         .i_ifu_req_valid (iv),
         .o_ifu_req_ready (ifu_rdy),
         .i_ifu_req_addr  (iaddr),
         .o_ifu_rsp_valid (ifu_rv),
         .i_ifu_rsp_ready (irr),
         .o_ifu_rsp_data  (ifu_rd),
         .i_lsu_req_valid (lv),
         .o_lsu_req_ready (lsu_rdy),
         .i_lsu_req_addr  (laddr),
         .i_lsu_req_wen   (lwen),
         .i_lsu_req_wdata (lwdata),
         .i_lsu_req_wmask (lwmask),
         .o_lsu_rsp_valid (lsu_rv),
         .i_lsu_rsp_ready (lrr),
         .o_lsu_rsp_data  (lsu_rd),
         .o_mem_raddr     (raddr),
         .o_mem_waddr     (waddr),
         .o_mem_wdata     (wdata_o),
         .o_mem_wmask     (wmask_o),
         .o_mem_read_en   (rd_en),
         .o_mem_write_en  (wr_en),
         .i_mem_rdata     (rdata)
      );

      // Model + monitor: free whenever no response is outstanding.
      always @(negedge clk) begin : mon
         logic gi, gl, ow;
         acc_t e;
         rsp_t r;
         gi = 1'b0;
         gl = 1'b0;
         if (rsp_q.size() == 0 && !rst) begin
            if (iv && lv) begin
`ifdef MEM_ARB_RR_EN
               gl = (last == OWNER_IFU);
               gi = !gl;
`else
               gl = 1'b1;
`endif
            end else begin
               gi = iv;
               gl = lv;
            end
         end
         chk(LAT, "ifu_req_ready", 64'(ifu_rdy), 64'(gi));
         chk(LAT, "lsu_req_ready", 64'(lsu_rdy), 64'(gl));

         if (rd_en || wr_en) begin
            if (rst || acc_q.size() == 0) begin
               chk(LAT, "strobe_unexpected", 64'({rd_en, wr_en}), 64'(0));
            end else begin
               e = acc_q.pop_front();
               chk(LAT, "access_cycle", 64'(cyc), 64'(e.due));
               chk(LAT, "strobe_kind", 64'({rd_en, wr_en}), 64'({!e.wen, e.wen}));
               if (e.wen) begin
                  chk(LAT, "mem_waddr", waddr, e.addr);
                  chk(LAT, "mem_wdata", wdata_o, e.wdata);
                  chk(LAT, "mem_wmask", 64'(wmask_o), 64'(e.wmask));
               end else begin
                  chk(LAT, "mem_raddr", raddr, e.addr);
               end
            end
         end else if (!rst && acc_q.size() != 0 && acc_q[0].due <= cyc) begin
            chk(LAT, "strobe_missing", 64'({rd_en, wr_en}), 64'({!acc_q[0].wen, acc_q[0].wen}));
            void'(acc_q.pop_front());
         end

         if (rsp_q.size() != 0 && rsp_q[0].first <= cyc) begin
            ow = rsp_q[0].owner;
            chk(LAT, "rsp_valid", 64'({ifu_rv, lsu_rv}), 64'({ow == OWNER_IFU, ow == OWNER_LSU}));
            chk(LAT, "rsp_data", (ow == OWNER_LSU) ? lsu_rd : ifu_rd, rsp_q[0].data);
            if (!rst && ((ow == OWNER_LSU) ? lrr : irr)) void'(rsp_q.pop_front());
         end else if (ifu_rv || lsu_rv) begin
            chk(LAT, "rsp_unexpected", 64'({ifu_rv, lsu_rv}), 64'(0));
         end

         if (rst) begin
            acc_q.delete();
            rsp_q.delete();
            last = OWNER_IFU;
         end else if (gi || gl) begin
            e.due   = cyc + LAT;
            e.wen   = gl & lwen;
            e.addr  = gl ? laddr : iaddr;
            e.wdata = lwdata;
            e.wmask = lwmask;
            acc_q.push_back(e);
            r.first = cyc + LAT + 1;
            r.owner = gl ? OWNER_LSU : OWNER_IFU;
            r.data  = e.wen ? 64'd0 : mem_fn(e.addr);
            rsp_q.push_back(r);
            if (gl) n_acc_l++;
            else n_acc_i++;
            last = r.owner;
         end
         cyc++;
      end

      initial begin : drv
         int seen_i, seen_l, bi, bl, ki, kl, budget;
         rst = 1'b1; iv = 1'b0; lv = 1'b0; lwen = 1'b0; irr = 1'b1; lrr = 1'b1;
         iaddr = '0; laddr = '0; lwdata = '0; lwmask = '0;
         seen_i = 0; seen_l = 0;
         repeat (3) @(posedge clk);
         #1 rst = 1'b0;
         @(negedge clk);
         chk(LAT, "reset_raddr", raddr, 64'd0);
         chk(LAT, "reset_waddr", waddr, 64'd0);
         chk(LAT, "reset_wdata", wdata_o, 64'd0);
         chk(LAT, "reset_wmask", 64'(wmask_o), 64'd0);
         chk(LAT, "reset_ifu_rsp_data", ifu_rd, 64'd0);
         chk(LAT, "reset_lsu_rsp_data", lsu_rd, 64'd0);

         // 0 fetch, 1 store, 2 conflict, 3 held response, 4 reset in store access, 5 continuous conflict
         for (int ph = 0; ph < 6; ph++) begin
            @(posedge clk); #1;
            bi = n_acc_i; bl = n_acc_l; ki = 0; kl = 0; budget = 300;
            case (ph)
               0: begin iv = 1'b1; iaddr = 64'h8000_0000; end
               1: begin lv = 1'b1; lwen = 1'b1; laddr = 64'h8000_0010; lwdata = 64'hAABB; lwmask = 8'h0F; end
               2: begin iv = 1'b1; iaddr = 64'h8000_0100; lv = 1'b1; lwen = 1'b0; laddr = 64'h8000_0200; end
               3: begin iv = 1'b1; iaddr = 64'h8000_0000; irr = 1'b0; end
               4: begin lv = 1'b1; lwen = 1'b1; laddr = 64'h8000_0040; lwdata = 64'h0123_4567_89AB_CDEF; lwmask = 8'hFF; end
               default: begin iv = 1'b1; lv = 1'b1; lwen = 1'b0; iaddr = 64'h8000_1000; laddr = 64'h8000_2000; end
            endcase
            while ((iv || lv || rst || rsp_q.size() != 0) && budget > 0) begin
               @(posedge clk); #1;
               budget--; ki++; kl++;
               if (n_acc_i != seen_i) begin
                  seen_i = n_acc_i; ki = 0; iaddr += 64'h8;
                  iv = (ph == 5) && (seen_i - bi < 4);
                  if (ph == 3) begin lv = 1'b1; lwen = 1'b0; laddr = 64'h8000_0300; end
               end
               if (n_acc_l != seen_l) begin
                  seen_l = n_acc_l; kl = 0; laddr += 64'h8;
                  lv = (ph == 5) && (seen_l - bl < 4);
               end
               if (ph == 3) irr = (ki > LAT + 6);
               if (rst) rst = 1'b0;
               else if (ph == 4 && !lv && kl == LAT - 1 && rsp_q.size() != 0) rst = 1'b1;
            end
            chk(LAT, "phase_drained", 64'({iv, lv, rsp_q.size() != 0}), 64'(0));
            irr = 1'b1;
         end

         for (int t = 0; t < 600; t++) begin
            @(posedge clk); #1;
            if (n_acc_i != seen_i) begin seen_i = n_acc_i; iv = 1'b0; end
            if (n_acc_l != seen_l) begin seen_l = n_acc_l; lv = 1'b0; end
            if (!iv) begin
               if ($urandom_range(0, 2) == 0) begin iv = 1'b1; iaddr = {$urandom, $urandom}; end
            end else if ($urandom_range(0, 15) == 0) iv = 1'b0;
            if (!lv) begin
               if ($urandom_range(0, 2) == 0) begin
                  lv = 1'b1; laddr = {$urandom, $urandom}; lwen = 1'($urandom_range(0, 1));
                  lwdata = {$urandom, $urandom}; lwmask = 8'($urandom);
               end
            end else if ($urandom_range(0, 15) == 0) lv = 1'b0;
            irr = ($urandom_range(0, 3) != 0);
            lrr = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 79) == 0);
         end

         @(posedge clk); #1;
         iv = 1'b0; lv = 1'b0; rst = 1'b0; irr = 1'b1; lrr = 1'b1;
         budget = 100;
         while (rsp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
         end
         chk(LAT, "final_drain", 64'(rsp_q.size()), 64'(0));
         done_b = 1'b1;
      end
   end

   initial begin : fin
      int budget;
      budget = 20000;
      while (!(gen_lat[0].done_b && gen_lat[1].done_b) && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      chk(0, "all_done", 64'({gen_lat[0].done_b, gen_lat[1].done_b}), 64'(3));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
